clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 127 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Glitch-free clock divider (N = 2/4/8/16) with run/stop control.
// Ratio changes and stops happen only at the falling boundary of div_clk.
module clk_div_ctrl #(
    parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic       div_clk,
    output logic       div_tick,
    output logic [1:0] cur_sel,
    output logic       chg_done,
    output logic       active
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       div_q, div_d;
    logic       tick_q, tick_d;
    logic       chg_q, chg_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] pend_q, pend_d;
    logic       rdy_q;

    logic [2:0] half_m1;
    logic       wrap, fall, accept;

    always_comb begin
        case (sel_q)
            2'd0:    half_m1 = 3'd0;
            2'd1:    half_m1 = 3'd1;
            2'd2:    half_m1 = 3'd3;
            default: half_m1 = 3'd7;
        endcase
    end

    assign wrap      = (cnt_q == half_m1);
    assign fall      = wrap && div_q;
    // rdy_q keeps req_ready low until the first edge after reset release
    assign req_ready = rdy_q && (state_q != ST_DRAIN);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        chg_d   = 1'b0;
        sel_d   = sel_q;
        pend_d  = pend_q;
        case (state_q)
            ST_STOP: begin
                cnt_d = 3'd0;
                div_d = 1'b0;
                if (accept) begin
                    sel_d = req_sel;
                    chg_d = 1'b1;
                end else if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // The falling boundary wrap already leaves div_clk=0, cnt=0
                if (wrap) begin
                    cnt_d  = 3'd0;
                    div_d  = ~div_q;
                    tick_d = ~div_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
                if (state_q == ST_RUN) begin
                    if (!run && fall)
                        state_d = ST_STOP;
                    if (accept) begin
                        if (req_sel == sel_q) begin
                            chg_d = 1'b1;
                        end else begin
                            pend_d  = req_sel;
                            state_d = ST_DRAIN;
                        end
                    end
                end else if (fall) begin
                    sel_d   = pend_q;
                    chg_d   = 1'b1;
                    state_d = run ? ST_RUN : ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STOP;
            cnt_q   <= 3'd0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
            chg_q   <= 1'b0;
            sel_q   <= DEFAULT_SEL;
            pend_q  <= DEFAULT_SEL;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            chg_q   <= chg_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            rdy_q   <= 1'b1;
        end
    end

    assign div_clk  = div_q;
    assign div_tick = tick_q;
    assign chg_done = chg_q;
    assign cur_sel  = sel_q;
    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: inputs change and outputs are sampled on the falling clk edge.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, run, req_valid;
    logic [1:0] req_sel;
    logic       req_ready, div_clk, div_tick, chg_done, active;
    logic [1:0] cur_sel;
    int         ntests = 0;
    int         nfail  = 0;

    clk_div_ctrl #(.DEFAULT_SEL(2'd0)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .div_clk  (div_clk),
        .div_tick (div_tick),
        .cur_sel  (cur_sel),
        .chg_done (chg_done),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // n cycles with no input change; bit i of each pattern is the i-th sample
    task automatic wave(input string tag, input int n, input logic [31:0] dp, input logic [31:0] tp);
        logic [31:0] d, t;
        d = dp;
        t = tp;
        for (int i = 0; i < n; i++) begin
            cyc();
            chk($sformatf("%s.div[%0d]", tag, i), {7'd0, div_clk}, {7'd0, d[i]});
            chk($sformatf("%s.tick[%0d]", tag, i), {7'd0, div_tick}, {7'd0, t[i]});
        end
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; req_valid = 1'b0; req_sel = 2'd0;
        cyc(); cyc();
        chk("rst.div",    {7'd0, div_clk},   8'd0);
        chk("rst.tick",   {7'd0, div_tick},  8'd0);
        chk("rst.chg",    {7'd0, chg_done},  8'd0);
        chk("rst.active", {7'd0, active},    8'd0);
        chk("rst.ready",  {7'd0, req_ready}, 8'd0);
        chk("rst.sel",    {6'd0, cur_sel},   8'd0);

        // divide-by-2 straight out of reset
        reset_n = 1'b1; run = 1'b1;
        cyc();
        chk("r0.active", {7'd0, active},    8'd1);
        chk("r0.ready",  {7'd0, req_ready}, 8'd1);
        chk("r0.div",    {7'd0, div_clk},   8'd0);
        wave("n2", 5, 32'b10101, 32'b10101);

        // stop on the falling boundary
        run = 1'b0;
        cyc();
        chk("stop.div",    {7'd0, div_clk}, 8'd0);
        chk("stop.active", {7'd0, active},  8'd0);
        wave("stop", 2, 32'b00, 32'b00);

        // select change while stopped
        req_valid = 1'b1; req_sel = 2'd2;
        chk("stop.ready", {7'd0, req_ready}, 8'd1);
        cyc();
        req_valid = 1'b0;
        chk("ssel.chg",    {7'd0, chg_done}, 8'd1);
        chk("ssel.sel",    {6'd0, cur_sel},  8'd2);
        chk("ssel.active", {7'd0, active},   8'd0);
        cyc();
        chk("ssel.chg0", {7'd0, chg_done}, 8'd0);

        // divide-by-8: first rise 4 cycles after entering RUN
        run = 1'b1;
        cyc();
        chk("n8.enter", {7'd0, active}, 8'd1);
        wave("n8", 12, 32'b1000_0111_1000, 32'b1000_0000_1000);

        // same-select request: acknowledged, waveform untouched
        req_valid = 1'b1; req_sel = 2'd2;
        cyc();
        req_valid = 1'b0;
        chk("same.chg", {7'd0, chg_done}, 8'd1);
        chk("same.div", {7'd0, div_clk},  8'd1);
        cyc();
        chk("same.chg0", {7'd0, chg_done}, 8'd0);
        chk("same.div2", {7'd0, div_clk},  8'd1);

        // 8 -> 16 change late in the high phase
        req_valid = 1'b1; req_sel = 2'd3;
        chk("c16.ready0", {7'd0, req_ready}, 8'd1);
        cyc();
        req_valid = 1'b0;
        chk("c16.ready", {7'd0, req_ready}, 8'd0);
        chk("c16.div",   {7'd0, div_clk},   8'd1);
        chk("c16.osel",  {6'd0, cur_sel},   8'd2);
        chk("c16.chg0",  {7'd0, chg_done},  8'd0);
        cyc();
        chk("c16.fall", {7'd0, div_clk},   8'd0);
        chk("c16.chg",  {7'd0, chg_done},  8'd1);
        chk("c16.sel",  {6'd0, cur_sel},   8'd3);
        chk("c16.rdy",  {7'd0, req_ready}, 8'd1);
        wave("n16", 11, 32'b111_1000_0000, 32'b000_1000_0000);

        // 16 -> 2 change in the middle of the high phase
        req_valid = 1'b1; req_sel = 2'd0;
        cyc();
        req_valid = 1'b0;
        chk("c2.ready", {7'd0, req_ready}, 8'd0);
        chk("c2.div",   {7'd0, div_clk},   8'd1);
        chk("c2.osel",  {6'd0, cur_sel},   8'd3);
        wave("c2.hold", 3, 32'b111, 32'b000);
        chk("c2.ready2", {7'd0, req_ready}, 8'd0);
        cyc();
        chk("c2.fall", {7'd0, div_clk},   8'd0);
        chk("c2.chg",  {7'd0, chg_done},  8'd1);
        chk("c2.sel",  {6'd0, cur_sel},   8'd0);
        chk("c2.rdy",  {7'd0, req_ready}, 8'd1);
        wave("n2b", 3, 32'b101, 32'b101);

        // 2 -> 4 change issued on a falling-boundary cycle
        req_valid = 1'b1; req_sel = 2'd1;
        cyc();
        req_valid = 1'b0;
        chk("c4.div",   {7'd0, div_clk},   8'd0);
        chk("c4.ready", {7'd0, req_ready}, 8'd0);
        cyc();
        chk("c4.div1",  {7'd0, div_clk},  8'd1);
        chk("c4.tick1", {7'd0, div_tick}, 8'd1);
        chk("c4.osel",  {6'd0, cur_sel},  8'd0);
        cyc();
        chk("c4.fall", {7'd0, div_clk},  8'd0);
        chk("c4.chg",  {7'd0, chg_done}, 8'd1);
        chk("c4.sel",  {6'd0, cur_sel},  8'd1);
        wave("n4", 4, 32'b0110, 32'b0010);

        // drop run during the low phase: full low + full high, then stop
        run = 1'b0;
        wave("drain4", 3, 32'b110, 32'b010);
        chk("drain4.active", {7'd0, active}, 8'd1);
        cyc();
        chk("s4.div",    {7'd0, div_clk},  8'd0);
        chk("s4.active", {7'd0, active},   8'd0);
        chk("s4.tick",   {7'd0, div_tick}, 8'd0);
        wave("s4", 2, 32'b00, 32'b00);

        // reset while a change is pending
        run = 1'b1;
        cyc();
        chk("rd.active", {7'd0, active}, 8'd1);
        req_valid = 1'b1; req_sel = 2'd3;
        cyc();
        req_valid = 1'b0;
        chk("rd.ready", {7'd0, req_ready}, 8'd0);
        cyc();
        chk("rd.div",  {7'd0, div_clk}, 8'd1);
        chk("rd.osel", {6'd0, cur_sel}, 8'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rd.rdiv",    {7'd0, div_clk},   8'd0);
        chk("rd.rsel",    {6'd0, cur_sel},   8'd0);
        chk("rd.rchg",    {7'd0, chg_done},  8'd0);
        chk("rd.rready",  {7'd0, req_ready}, 8'd0);
        chk("rd.ractive", {7'd0, active},    8'd0);
        cyc();
        chk("rd.hchg", {7'd0, chg_done}, 8'd0);
        reset_n = 1'b1;
        cyc();
        chk("rr.active", {7'd0, active},    8'd1);
        chk("rr.ready",  {7'd0, req_ready}, 8'd1);
        chk("rr.chg",    {7'd0, chg_done},  8'd0);
        chk("rr.sel",    {6'd0, cur_sel},   8'd0);
        wave("rr", 4, 32'b0101, 32'b0101);
        chk("rr.chg2", {7'd0, chg_done}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
